// File: rtl/planificador_wrr_pkg.sv
// Shared definitions for the weighted round-robin egress scheduler.
package planificador_wrr_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    INIT   = 2'd1,
    IDLE   = 2'd2,
    ACTIVO = 2'd3
  } estado_t;

  localparam int unsigned NUM_CLASES = 4;

  localparam int unsigned PESO0_DEF = 4;
  localparam int unsigned PESO1_DEF = 3;
  localparam int unsigned PESO2_DEF = 2;
  localparam int unsigned PESO3_DEF = 1;

  // A zero weight would starve its class forever, so it is promoted to one.
  function automatic logic [3:0] peso_efectivo(input int unsigned p);
    if (p == 0) return 4'd1;
    if (p > 15) return 4'd15;
    return p[3:0];
  endfunction

endpackage

// File: rtl/planificador_wrr_selector_rr.sv
// Rotating-priority picker: first eligible class at or above ptr, wrapping.
module selector_rr
  import planificador_wrr_pkg::*;
(
  input  logic [NUM_CLASES-1:0] elegible,
  input  logic [1:0]            ptr,
  output logic [NUM_CLASES-1:0] grant,
  output logic                  valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CLASES; k++) begin
      if (!valid && elegible[ptr + 2'(k)]) begin
        grant[ptr + 2'(k)] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/planificador_wrr.sv
// Weighted round-robin drain of four class FIFOs into one egress FIFO.
module planificador_wrr
  import planificador_wrr_pkg::*;
#(
  parameter int unsigned TAMANO_DATOS = 12,
  parameter int unsigned PESO0        = PESO0_DEF,
  parameter int unsigned PESO1        = PESO1_DEF,
  parameter int unsigned PESO2        = PESO2_DEF,
  parameter int unsigned PESO3        = PESO3_DEF
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic                    almost_full_out,
  output logic [3:0]              pop,
  output logic                    push_out,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic [1:0]              clase_activa,
  output logic                    idle
);

  localparam logic [NUM_CLASES-1:0][3:0] PESOS = {
    peso_efectivo(PESO3), peso_efectivo(PESO2),
    peso_efectivo(PESO1), peso_efectivo(PESO0)
  };

  estado_t                       estado, estado_sig;
  logic [NUM_CLASES-1:0][3:0]    creditos;
  logic [1:0]                    ptr;
  logic [NUM_CLASES-1:0]         elegible, grant;
  logic                          valid, recarga, conceder;
  logic [1:0]                    ganador, sel_q;
  logic                          push_q;
  logic [TAMANO_DATOS-1:0]       dato_mux, dato_hold;

  always_comb begin
    elegible = '0;
    for (int unsigned i = 0; i < NUM_CLASES; i++)
      elegible[i] = !empty[i] && (creditos[i] != 4'd0);
  end

  // Reload only looks at non-empty classes, so idle classes never hold it back.
  assign recarga = ((estado == IDLE) || (estado == ACTIVO)) && !(&empty) && !(|elegible);

  selector_rr u_selector_rr (
    .elegible (elegible),
    .ptr      (ptr),
    .grant    (grant),
    .valid    (valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= RESET;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      RESET:  estado_sig = INIT;
      INIT:   estado_sig = IDLE;
      IDLE:   if ((|elegible) && !almost_full_out) estado_sig = ACTIVO;
      ACTIVO: if ((&empty) || almost_full_out) estado_sig = IDLE;
      default: estado_sig = RESET;
    endcase
  end

  always_comb begin
    idle     = (estado == IDLE);
    conceder = (estado == ACTIVO) && !almost_full_out && valid;
    pop      = conceder ? grant : '0;
    ganador  = '0;
    for (int unsigned i = 0; i < NUM_CLASES; i++)
      if (grant[i]) ganador = 2'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      creditos <= '0;
      ptr      <= '0;
    end else if ((estado == INIT) || recarga) begin
      creditos <= PESOS;
    end else if (conceder) begin
      if (creditos[ganador] != 4'd0) creditos[ganador] <= creditos[ganador] - 4'd1;
      ptr <= ganador + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_q    <= 1'b0;
      sel_q     <= '0;
      dato_hold <= '0;
    end else begin
      push_q <= conceder;
      if (conceder) sel_q <= ganador;
      if (push_q) dato_hold <= dato_mux;
    end
  end

  // Class FIFO read data lands the cycle after its pop, so the mux follows the registered select.
  always_comb begin
    dato_mux = data_in0;
    unique case (sel_q)
      2'd0: dato_mux = data_in0;
      2'd1: dato_mux = data_in1;
      2'd2: dato_mux = data_in2;
      2'd3: dato_mux = data_in3;
      default: dato_mux = data_in0;
    endcase
  end

  assign push_out     = push_q;
  assign data_out     = push_q ? dato_mux : dato_hold;
  assign clase_activa = sel_q;

endmodule
